// File: rtl/uart_boot_loader_pkg.sv
// Shared state encoding and default protocol bytes for the UART boot loader.
// No ports; imported by uart_boot_loader. CHK exists only with BOOT_CHECKSUM_EN.
package boot_pkg;

    localparam int LEN_BYTES = 4;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0] NAK_BYTE_DEF = 8'hEE;

    typedef enum logic [2:0] {
        RECV_LEN  = 3'd0,
        RECV_WORD = 3'd1,
        WRITE     = 3'd2,
        ACK       = 3'd3,
        RUN       = 3'd4,
        ERROR     = 3'd5
`ifdef BOOT_CHECKSUM_EN
        ,
        CHK       = 3'd6
`endif
    } boot_state_t;

endpackage

// File: rtl/uart_boot_loader_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on CLK.
// Ports: clk, rst_n (raw async reset in), rst_n_sync (conditioned reset out).
module rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_n_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed program image from UART into instruction memory,
// answers ACK/NAK over UART, then releases the core through cpu_run.
// Ports: CLK, RST_N (async active-low); reload restarts the load;
//   rx_valid/rx_data byte in; tx_valid/tx_ready/tx_data byte out;
//   imem_we/imem_addr/imem_wdata memory write; cpu_run, err, status LEDs.
// Build option BOOT_CHECKSUM_EN: a trailing XOR checksum byte is verified.
import boot_pkg::*;

module uart_boot_loader #(
    parameter int         INST_MEM_WIDTH = 15,
    parameter int         WORD_BYTES     = 4,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEF
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      reload,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    input  logic                      tx_ready,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    output logic                      imem_we,
    output logic [INST_MEM_WIDTH-1:0] imem_addr,
    output logic [8*WORD_BYTES-1:0]   imem_wdata,
    output logic                      cpu_run,
    output logic                      err,
    output logic [7:0]                status
);

    localparam int WW   = 8 * WORD_BYTES;
    localparam int IDXW = INST_MEM_WIDTH + 1;

    localparam logic [32:0] CAP = 33'd1 << INST_MEM_WIDTH;

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t AFTER_DATA = CHK;
`else
    localparam boot_state_t AFTER_DATA = ACK;
`endif

    logic rst_n_s;

    rst_sync u_rst_sync (
        .clk        (CLK),
        .rst_n      (RST_N),
        .rst_n_sync (rst_n_s)
    );

    boot_state_t     state, state_d;
    logic [31:0]     length, length_d;
    logic [WW-1:0]   word, word_d;
    logic [7:0]      byte_cnt, byte_cnt_d;
    logic [IDXW-1:0] word_idx, word_idx_d;
    logic            nak_done, nak_done_d;

    logic [31:0]     len_sh;
    logic [WW-1:0]   word_sh;
    logic            last_word;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum, csum_d;
    logic [7:0] chk_rx, chk_rx_d;
    logic       chk_have, chk_have_d;
    logic [7:0] chk_byte;
`endif

    always_ff @(posedge CLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state    <= RECV_LEN;
            length   <= '0;
            word     <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            nak_done <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum     <= '0;
            chk_rx   <= '0;
            chk_have <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            length   <= length_d;
            word     <= word_d;
            byte_cnt <= byte_cnt_d;
            word_idx <= word_idx_d;
            nak_done <= nak_done_d;
`ifdef BOOT_CHECKSUM_EN
            csum     <= csum_d;
            chk_rx   <= chk_rx_d;
            chk_have <= chk_have_d;
`endif
        end
    end

    always_comb begin
        state_d    = state;
        length_d   = length;
        word_d     = word;
        byte_cnt_d = byte_cnt;
        word_idx_d = word_idx;
        nak_done_d = nak_done;

        // Both length and words arrive LSB first, so shift in from the top.
        len_sh    = {rx_data, length[31:8]};
        word_sh   = (WW'(rx_data) << (WW - 8)) | (word >> 8);
        last_word = (32'(word_idx) == length - 32'd1);

        imem_we  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        cpu_run  = 1'b0;
        err      = 1'b0;

`ifdef BOOT_CHECKSUM_EN
        csum_d     = csum;
        chk_rx_d   = chk_rx;
        chk_have_d = chk_have;
        chk_byte   = chk_have ? chk_rx : rx_data;
        if (rx_valid && (state == RECV_LEN || state == RECV_WORD ||
                         (state == WRITE && !last_word))) begin
            csum_d = csum ^ rx_data;
        end
`endif

        unique case (state)
            RECV_LEN: begin
                if (rx_valid) begin
                    length_d = len_sh;
                    if (byte_cnt == 8'(LEN_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        if (len_sh == 32'd0) begin
                            state_d = AFTER_DATA;
                        end else if ({1'b0, len_sh} > CAP) begin
                            state_d = ERROR;
                        end else begin
                            state_d = RECV_WORD;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt + 8'd1;
                    end
                end
            end

            RECV_WORD: begin
                if (rx_valid) begin
                    word_d = word_sh;
                    if (byte_cnt == 8'(WORD_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt + 8'd1;
                    end
                end
            end

            WRITE: begin
                imem_we    = 1'b1;
                word_idx_d = word_idx + IDXW'(1);
                if (last_word) begin
                    state_d = AFTER_DATA;
`ifdef BOOT_CHECKSUM_EN
                    // Checksum byte may land while the last word is written.
                    if (rx_valid) begin
                        chk_rx_d   = rx_data;
                        chk_have_d = 1'b1;
                    end
`endif
                end else begin
                    state_d = RECV_WORD;
                    // A byte arriving here opens the next word.
                    if (rx_valid) begin
                        word_d     = word_sh;
                        byte_cnt_d = 8'd1;
                        if (WORD_BYTES == 1) begin
                            byte_cnt_d = '0;
                            state_d    = WRITE;
                        end
                    end
                end
            end

`ifdef BOOT_CHECKSUM_EN
            CHK: begin
                if (chk_have || rx_valid) begin
                    chk_have_d = 1'b0;
                    state_d    = (chk_byte == csum) ? ACK : ERROR;
                end
            end
`endif

            ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                cpu_run = 1'b1;
            end

            ERROR: begin
                err = 1'b1;
                if (!nak_done) begin
                    tx_valid = 1'b1;
                    tx_data  = NAK_BYTE;
                    if (tx_ready) begin
                        nak_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = RECV_LEN;
            end
        endcase

        // Reload wins over everything, including a same-cycle rx byte.
        if (reload) begin
            state_d    = RECV_LEN;
            length_d   = '0;
            byte_cnt_d = '0;
            word_idx_d = '0;
            nak_done_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_d     = '0;
            chk_have_d = 1'b0;
`endif
        end
    end

    assign imem_addr  = word_idx[INST_MEM_WIDTH-1:0];
    assign imem_wdata = word;
    assign status     = {state, err, cpu_run, word_idx[2:0]};

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a queue scoreboard for
// memory writes and transmitted bytes.
module tb_uart_boot_loader;

    localparam int AW = 4;
    localparam int WB = 4;

`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          CLK      = 1'b0;
    logic          RST_N    = 1'b1;
    logic          reload   = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          tx_ready = 1'b1;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          err;
    logic [7:0]    status;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] exp_w[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  stim[$];

    uart_boot_loader #(
        .INST_MEM_WIDTH (AW),
        .WORD_BYTES     (WB)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .reload     (reload),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .err        (err),
        .status     (status)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] wr(input int a, input logic [31:0] d);
        return {28'd0, 4'(a), d};
    endfunction

    // Scoreboard monitor: every write and every tx handshake must be expected.
    always @(negedge CLK) begin
        if (imem_we) begin
            if (exp_w.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected",
                         imem_addr, imem_wdata);
            end else begin
                check("imem_write", {28'd0, imem_addr, imem_wdata},
                      exp_w.pop_front());
            end
        end
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_tx: byte %h, none expected", tx_data);
            end else begin
                check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input int gap);
        while (stim.size() > 0) begin
            rx_valid = 1'b1;
            rx_data  = stim.pop_front();
            tick(1);
            rx_valid = 1'b0;
            tick(gap);
        end
    endtask

    task automatic add_csum(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'h00;
        foreach (stim[i]) x ^= stim[i];
        if (CSUM) stim.push_back(x ^ flip);
    endtask

    // Length + n words of consecutive byte values starting at 'first'.
    task automatic image(input int n, input logic [7:0] first);
        logic [7:0]  b;
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) stim.push_back(8'(n >> (8 * i)));
        b = first;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < WB; k++) begin
                stim.push_back(b);
                d[8*k +: 8] = b;
                b = b + 8'd1;
            end
            exp_w.push_back(wr(w, d));
        end
    endtask

    task automatic pulse_reload(input bit with_rx);
        reload = 1'b1;
        if (with_rx) begin
            rx_valid = 1'b1;
            rx_data  = 8'h99;
        end
        tick(1);
        reload   = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic wait_for(input string name, input bit use_err, input int max);
        int i;
        i = 0;
        while (i < max && !(use_err ? err : cpu_run)) begin
            tick(1);
            i++;
        end
        check(name, 64'(use_err ? err : cpu_run), 64'd1);
    endtask

    initial begin
        bit hold_ok;
        int i;

        #2 RST_N = 1'b0;
        #1 check("reset_outputs",
                 64'({tx_valid, tx_data, imem_we, cpu_run, err, status}), 64'd0);
        #20 RST_N = 1'b1;
        tick(4);
        check("reset_status", 64'(status), 64'd0);

        // Two-word image, ACK held off for 50 cycles.
        stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88};
        exp_w.push_back(wr(0, 32'h44332211));
        exp_w.push_back(wr(1, 32'h88776655));
        add_csum(8'h00);
        exp_tx.push_back(8'hAA);
        tx_ready = 1'b0;
        send(2);
        i = 0;
        while (i < 20 && !tx_valid) begin
            tick(1);
            i++;
        end
        check("ack_pending", 64'({tx_valid, tx_data}), 64'h1AA);
        hold_ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (!(tx_valid && tx_data == 8'hAA && !cpu_run)) hold_ok = 1'b0;
            tick(1);
        end
        check("ack_hold", 64'(hold_ok), 64'd1);
        check("two_words_written", 64'(exp_w.size()), 64'd0);
        tx_ready = 1'b1;
        tick(1);
        check("run_after_hs", 64'(cpu_run), 64'd1);
        check("run_status", 64'(status[7:5]), 64'd4);

        // Bytes in RUN are ignored.
        stim = {8'h05, 8'h00, 8'h00, 8'h00, 8'h01};
        send(0);
        tick(3);
        check("run_ignore", 64'({cpu_run, status[7:5]}), 64'h0C);

        pulse_reload(1'b0);
        check("reload_clear", 64'({cpu_run, tx_valid, err, status}), 64'd0);

        // Empty image.
        image(0, 8'h00);
        add_csum(8'h00);
        exp_tx.push_back(8'hAA);
        send(1);
        wait_for("len0_run", 1'b0, 50);
        check("len0_idx", 64'(status[2:0]), 64'd0);

        // Oversized image: one NAK, then idle.
        pulse_reload(1'b0);
        stim = {8'h11, 8'h00, 8'h00, 8'h00};
        exp_tx.push_back(8'hEE);
        send(1);
        wait_for("len17_err", 1'b1, 50);
        tick(20);
        check("len17_state", 64'({cpu_run, tx_valid, status[7:5]}), 64'h05);
        check("nak_once", 64'(exp_tx.size()), 64'd0);

        pulse_reload(1'b0);
        check("reload_err_clear", 64'({err, status}), 64'd0);

        // Full capacity, bytes back to back across every WRITE.
        image(16, 8'h00);
        add_csum(8'h00);
        exp_tx.push_back(8'hAA);
        send(0);
        wait_for("len16_run", 1'b0, 200);
        check("len16_all_written", 64'(exp_w.size()), 64'd0);

        // Reload partway through the second word; rx byte in that cycle dropped.
        pulse_reload(1'b0);
        image(3, 8'h40);
        while (stim.size() > 10) void'(stim.pop_back());
        while (exp_w.size() > 1) void'(exp_w.pop_back());
        send(1);
        pulse_reload(1'b1);
        check("reload_mid", 64'({err, status}), 64'd0);
        check("reload_mid_words", 64'(exp_w.size()), 64'd0);
        image(2, 8'hA0);
        add_csum(8'h00);
        exp_tx.push_back(8'hAA);
        send(1);
        wait_for("reimage_run", 1'b0, 100);
        check("reimage_written", 64'(exp_w.size()), 64'd0);

`ifdef BOOT_CHECKSUM_EN
        // Corrupted checksum: words stay written, NAK sent.
        pulse_reload(1'b0);
        image(2, 8'h10);
        add_csum(8'h01);
        exp_tx.push_back(8'hEE);
        send(1);
        wait_for("csum_bad_err", 1'b1, 100);
        check("csum_bad_norun", 64'(cpu_run), 64'd0);
`endif

        tick(5);
        check("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
        check("wr_queue_empty", 64'(exp_w.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Boot-time program loader between the UART byte receiver/transmitter and the CPU core's instruction memory.
- Receives a length-prefixed program image over UART and writes it word by word into instruction memory.
- Acknowledges the load over UART, then releases the core by asserting cpu_run.
- Adds a proper reset and reload path to the top level; parametrised in memory depth and word width.

Parameters:
- INST_MEM_WIDTH, 15, instruction memory address width; capacity = 2^INST_MEM_WIDTH words.
- WORD_BYTES, 4, bytes per instruction word; word width = 8*WORD_BYTES.
- ACK_BYTE, 8'hAA, byte sent on successful load.
- NAK_BYTE, 8'hEE, byte sent on error.

Ports:
- CLK  in  1  system clock (clk_wiz output).
- RST_N  in  1  asynchronous, active-low reset.
- reload  in  1  single-cycle pulse (debounced switch); restarts the load.
- rx_valid  in  1  single-cycle pulse; rx_data is valid.
- rx_data  in  8  received byte.
- tx_ready  in  1  transmitter accepts a byte when tx_valid && tx_ready.
- tx_valid  out  1  byte pending for the transmitter.
- tx_data  out  8  byte to transmit.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  INST_MEM_WIDTH  write address.
- imem_wdata  out  8*WORD_BYTES  write data.
- cpu_run  out  1  core enable; held low throughout loading.
- err  out  1  sticky load error.
- status  out  8  LED view: {state[2:0], err, cpu_run, word_idx[2:0]}.

Behaviour:
- Reset: all outputs 0; state=RECV_LEN; byte_cnt=0; word_idx=0; length=0.
- Image format: 4 length bytes (N, little-endian, 32 bit), followed by N words of WORD_BYTES bytes each, each word little-endian (first byte goes to bits [7:0]).
- States: RECV_LEN, RECV_WORD, WRITE, ACK, RUN, ERROR.
- RECV_LEN: shift in 4 bytes. After the 4th byte:
  - N==0 -> ACK.
  - N>2^INST_MEM_WIDTH -> ERROR.
  - otherwise -> RECV_WORD.
- RECV_WORD: accumulate bytes into a word register. On the WORD_BYTES-th byte -> WRITE next cycle.
- WRITE: lasts exactly one cycle with imem_we=1, imem_addr=word_idx, imem_wdata=assembled word.
  - Latency: last byte's rx_valid to imem_we is 1 cycle.
  - Then word_idx++. If word_idx==N-1 -> ACK, else -> RECV_WORD.
  - An rx_valid arriving during WRITE is accepted as byte 0 of the next word; no byte is dropped.
- ACK: tx_valid=1, tx_data=ACK_BYTE, held until tx_ready. Handshake cycle -> RUN.
- RUN: cpu_run=1. rx bytes are ignored.
- ERROR: send NAK_BYTE once (same handshake as ACK), then idle with err=1. cpu_run stays 0. rx bytes are ignored.
- reload pulse, any state: next cycle cpu_run=0, tx_valid=0, err=0, counters cleared, state=RECV_LEN. Reload takes priority over a simultaneous rx_valid, which is dropped.
- RST_N asserted mid-load: immediate return to reset values. Memory contents are undefined/unchanged.
- word_idx width is INST_MEM_WIDTH+1 so that N=2^INST_MEM_WIDTH exactly fits without overflow. imem_addr is the low INST_MEM_WIDTH bits.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined:
  - One checksum byte follows the last word (CHK state between WRITE and ACK; also entered when N==0).
  - Checksum = XOR of all length and word bytes.
  - Match -> ACK; mismatch -> ERROR (NAK). Words already written remain in memory.
- Undefined: no CHK state; ACK follows the last write directly.

Decomposition:
- Package boot_pkg: state enum boot_state_t, LEN_BYTES=4, default ACK/NAK byte constants.
- One sub-module, rst_sync: 2-flop synchroniser giving RST_N asynchronous assert and synchronous deassert. The top level instantiates it in front of both this block and the core.

Test Plan:
- INST_MEM_WIDTH=4, WORD_BYTES=4; send length 02 00 00 00, then 11 22 33 44 55 66 77 88 -> writes addr0=32'h44332211, addr1=32'h88776655; tx 8'hAA; cpu_run rises 1 cycle after the tx handshake.
- Length 0 -> no imem_we; tx 8'hAA; cpu_run=1.
- Length 17 with INST_MEM_WIDTH=4 -> err=1; tx 8'hEE exactly once; cpu_run stays 0. Length 16 -> accepted; last write at addr 15.
- Back-to-back rx_valid on consecutive cycles across a WRITE boundary -> all words correct; none dropped.
- reload pulse during the second word -> state RECV_LEN, err=0; a subsequent full image loads correctly from addr 0.
- tx_ready held low for 50 cycles during ACK -> tx_valid and tx_data stable; cpu_run=0 until the handshake.
- (BOOT_CHECKSUM_EN) correct XOR -> 8'hAA; corrupted checksum -> 8'hEE and err=1.
